// File: rtl/rig_pkg.sv
// Shared definitions for the fault-injection rig capture path: result codes,
// receiver/frame state encodings and the UART bit-period derivation.
package rig_pkg;

  typedef enum logic [1:0] {
    RES_MATCH   = 2'b00,
    RES_FAULT   = 2'b01,
    RES_TIMEOUT = 2'b10,
    RES_FRAME   = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    F_IDLE,
    F_CAPTURE,
    F_REPORT
  } frame_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling timer and
// receiver FSM. Pulses byte_valid on a good stop bit, frame_err on a bad one.
module uart_rx_byte
  import rig_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= R_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = R_START;
      end
      R_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = R_IDLE;
          if (rx_sync_q) byte_valid = 1'b1;
          else           frame_err  = 1'b1;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  assign data = shift_q;

endmodule

// File: rtl/target_response_rx.sv
// Captures one ciphertext frame from the target UART after ARM and reports
// match / fault / timeout / framing error to the glitch sequencer.
module target_response_rx
  import rig_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 25000000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned FRAME_BYTES = 16,
  parameter int unsigned TIMEOUT_LEN = CLK_HZ / 10
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         RX,
  input  logic         ARM,
  input  logic [127:0] GOLDEN,
  output logic         BUSY,
  output logic         DONE,
  output logic [1:0]   RESULT,
  output logic [127:0] DATA,
  output logic [4:0]   BYTE_CNT
);

  localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned TW  = $clog2(TIMEOUT_LEN + 1);
  // The loading cycle counts as the first of TIMEOUT_LEN, so expiry lands
  // DONE exactly TIMEOUT_LEN cycles after ARM or the last byte_valid.
  localparam logic [TW-1:0] TmoLoad = TW'(TIMEOUT_LEN - 1);

  logic       byte_valid, frame_err;
  logic [7:0] rx_data;

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk       (CLK),
    .rst_n     (RST_N),
    .rx        (RX),
    .byte_valid(byte_valid),
    .data      (rx_data),
    .frame_err (frame_err)
  );

  frame_state_e   state_q, state_d;
  logic [127:0]   golden_q, golden_d;
  logic [127:0]   data_q, data_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  result_e        result_q, result_d;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= F_IDLE;
      golden_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      result_q <= RES_MATCH;
    end else begin
      state_q  <= state_d;
      golden_q <= golden_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    golden_d = golden_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    unique case (state_q)
      F_IDLE: begin
        if (ARM) begin
          state_d  = F_CAPTURE;
          golden_d = GOLDEN;
          data_d   = '0;
          cnt_d    = '0;
          tmo_d    = TmoLoad;
        end
      end
      F_CAPTURE: begin
        if (frame_err) begin
          result_d = RES_FRAME;
          state_d  = F_REPORT;
        end else if (byte_valid) begin
          for (int i = 0; i < 16; i++) begin
            if (cnt_q == 5'(i)) data_d[127-8*i -: 8] = rx_data;
          end
          cnt_d = cnt_q + 5'd1;
          tmo_d = TmoLoad;
          // Compare against the next DATA so the last byte is included and
          // RESULT is valid together with DONE.
          if (cnt_d == 5'(FRAME_BYTES)) begin
            state_d  = F_REPORT;
            result_d = (data_d != golden_q) ? RES_FAULT : RES_MATCH;
          end
        end else if (tmo_q <= TW'(1)) begin
          result_d = RES_TIMEOUT;
          state_d  = F_REPORT;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      F_REPORT: state_d = F_IDLE;
      default:  state_d = F_IDLE;
    endcase
  end

  assign BUSY     = (state_q == F_CAPTURE);
  assign DONE     = (state_q == F_REPORT);
  assign RESULT   = result_q;
  assign DATA     = data_q;
  assign BYTE_CNT = cnt_q;

endmodule

// File: tb/tb_target_response_rx.sv
// Directed bench for target_response_rx at 10 clocks per UART bit and a
// 400-cycle timeout.
`timescale 1ns/1ps
module tb_target_response_rx;

  localparam logic [127:0] G = 128'h3925841D02DC09FBDC118597196A0B32;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         RX = 1'b1;
  logic         ARM = 1'b0;
  logic [127:0] GOLDEN = '0;
  logic         BUSY, DONE;
  logic [1:0]   RESULT;
  logic [127:0] DATA;
  logic [4:0]   BYTE_CNT;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int busy_n = 0;
  time done_t = 0;
  time start_t = 0;
  time arm_t = 0;
  logic [1:0]   res_s;
  logic [127:0] data_s;
  logic [4:0]   cnt_s;

  target_response_rx #(
    .CLK_HZ     (1000000),
    .BAUD       (100000),
    .FRAME_BYTES(16),
    .TIMEOUT_LEN(400)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .RX      (RX),
    .ARM     (ARM),
    .GOLDEN  (GOLDEN),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .RESULT  (RESULT),
    .DATA    (DATA),
    .BYTE_CNT(BYTE_CNT)
  );

  always #5 CLK = ~CLK;

  // Snapshot the report and track BUSY on the falling edge.
  always @(negedge CLK) begin
    if (DONE) begin
      done_cnt = done_cnt + 1;
      done_t   = $time;
      res_s    = RESULT;
      data_s   = DATA;
      cnt_s    = BYTE_CNT;
    end
    if (BUSY) busy_n = busy_n + 1;
  end

  // All stimulus tasks are entered and left on a falling edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    repeat (10) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (10) @(negedge CLK);
    end
    RX = stop_bit;
    repeat (10) @(negedge CLK);
    RX = 1'b1;
  endtask

  task automatic send_bytes(input logic [127:0] f, input int first, input int last,
                            input int bad_stop);
    for (int k = first; k <= last; k++) send_byte(f[127-8*k -: 8], k != bad_stop);
  endtask

  task automatic arm_pulse(input logic [127:0] g);
    arm_t  = $time;
    ARM    = 1'b1;
    GOLDEN = g;
    @(negedge CLK);
    ARM = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (done_cnt < target && n < 800) begin
      @(negedge CLK);
      #1;
      n++;
    end
    checks++;
    if (done_cnt < target) begin
      errors++;
      $display("FAIL %s_done_wait: got %0d DONE pulses, required %0d", name, done_cnt, target);
    end
    repeat (5) @(negedge CLK);
    #1;
    checks++;
    if (done_cnt !== target) begin
      errors++;
      $display("FAIL %s_done_once: got %0d DONE pulses, required %0d", name, done_cnt, target);
    end
    @(negedge CLK);
  endtask

  function automatic int latency();
    return int'((done_t - start_t + 5) / 10);
  endfunction

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", DONE); end
    checks++; if (RESULT !== 2'b00) begin errors++; $display("FAIL rst_result: got %b required 00", RESULT); end
    checks++; if (DATA !== 128'h0) begin errors++; $display("FAIL rst_data: got %h required 0", DATA); end
    checks++; if (BYTE_CNT !== 5'd0) begin errors++; $display("FAIL rst_cnt: got %0d required 0", BYTE_CNT); end
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_match();
    int d0 = done_cnt;
    int lat;
    busy_n = 0;
    arm_pulse(G);
    start_t = $time;
    #1;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL match_busy_rise: got %b required 1", BUSY); end
    send_bytes(G, 0, 15, -1);
    wait_done(d0 + 1, "match");
    lat = latency();
    // 16th byte_valid lands ~1596 cycles after the first start bit; DONE one later.
    checks++; if (lat < 1596 || lat > 1598) begin errors++; $display("FAIL match_latency: got %0d required 1597+-1", lat); end
    checks++; if (res_s !== 2'b00) begin errors++; $display("FAIL match_result: got %b required 00", res_s); end
    checks++; if (cnt_s !== 5'd16) begin errors++; $display("FAIL match_cnt: got %0d required 16", cnt_s); end
    checks++; if (data_s !== G) begin errors++; $display("FAIL match_data: got %h required %h", data_s, G); end
    checks++;
    if (busy_n !== int'((done_t - arm_t) / 10) - 1) begin
      errors++;
      $display("FAIL match_busy_span: got %0d required %0d", busy_n, int'((done_t - arm_t) / 10) - 1);
    end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL match_busy_fall: got %b required 0", BUSY); end
  endtask

  task automatic test_fault();
    int d0 = done_cnt;
    logic [127:0] f;
    f = G;
    f[87:80] = 8'hDD;
    arm_pulse(G);
    send_bytes(f, 0, 15, -1);
    wait_done(d0 + 1, "fault");
    checks++; if (res_s !== 2'b01) begin errors++; $display("FAIL fault_result: got %b required 01", res_s); end
    checks++; if (data_s[87:80] !== 8'hDD) begin errors++; $display("FAIL fault_byte5: got %h required dd", data_s[87:80]); end
    checks++; if (cnt_s !== 5'd16) begin errors++; $display("FAIL fault_cnt: got %0d required 16", cnt_s); end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    int lat;
    arm_pulse(G);
    start_t = $time;
    send_bytes(G, 0, 6, -1);
    wait_done(d0 + 1, "timeout");
    lat = latency();
    // 7th byte_valid ~696 cycles after the first start bit, then 400 idle cycles.
    checks++; if (lat < 1095 || lat > 1097) begin errors++; $display("FAIL timeout_latency: got %0d required 1096+-1", lat); end
    checks++; if (res_s !== 2'b10) begin errors++; $display("FAIL timeout_result: got %b required 10", res_s); end
    checks++; if (cnt_s !== 5'd7) begin errors++; $display("FAIL timeout_cnt: got %0d required 7", cnt_s); end
    checks++; if (data_s[71:0] !== 72'h0) begin errors++; $display("FAIL timeout_tail: got %h required 0", data_s[71:0]); end
    checks++; if (data_s[127:72] !== G[127:72]) begin errors++; $display("FAIL timeout_head: got %h required %h", data_s[127:72], G[127:72]); end
  endtask

  task automatic test_framing();
    int d0 = done_cnt;
    int lat;
    arm_pulse(G);
    // Short low pulse: must be rejected as a glitch.
    RX = 1'b0;
    repeat (3) @(negedge CLK);
    RX = 1'b1;
    repeat (20) @(negedge CLK);
    start_t = $time;
    send_bytes(G, 0, 2, 2);
    wait_done(d0 + 1, "frame");
    lat = latency();
    checks++; if (lat < 296 || lat > 298) begin errors++; $display("FAIL frame_latency: got %0d required 297+-1", lat); end
    checks++; if (res_s !== 2'b11) begin errors++; $display("FAIL frame_result: got %b required 11", res_s); end
    checks++; if (cnt_s !== 5'd2) begin errors++; $display("FAIL frame_cnt: got %0d required 2", cnt_s); end
  endtask

  task automatic test_arm_guard();
    int d0 = done_cnt;
    // Bytes before ARM must be discarded.
    send_bytes(~G, 0, 2, -1);
    repeat (10) @(negedge CLK);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL prearm_done: got %0d required %0d", done_cnt, d0); end
    arm_pulse(G);
    send_bytes(G, 0, 7, -1);
    arm_pulse(~G);
    #1;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rearm_busy: got %b required 1", BUSY); end
    @(negedge CLK);
    send_bytes(G, 8, 15, -1);
    wait_done(d0 + 1, "rearm");
    checks++; if (res_s !== 2'b00) begin errors++; $display("FAIL rearm_result: got %b required 00", res_s); end
    checks++; if (cnt_s !== 5'd16) begin errors++; $display("FAIL rearm_cnt: got %0d required 16", cnt_s); end
    checks++; if (data_s !== G) begin errors++; $display("FAIL rearm_data: got %h required %h", data_s, G); end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    arm_pulse(G);
    send_bytes(G, 0, 8, -1);
    RX = 1'b0;
    repeat (25) @(negedge CLK);
    RST_N = 1'b0;
    RX = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", BUSY); end
    checks++; if (RESULT !== 2'b00) begin errors++; $display("FAIL midrst_result: got %b required 00", RESULT); end
    checks++; if (DATA !== 128'h0) begin errors++; $display("FAIL midrst_data: got %h required 0", DATA); end
    checks++; if (BYTE_CNT !== 5'd0) begin errors++; $display("FAIL midrst_cnt: got %0d required 0", BYTE_CNT); end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (20) @(negedge CLK);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midrst_no_done: got %0d required %0d", done_cnt, d0); end
    arm_pulse(G);
    send_bytes(G, 0, 15, -1);
    wait_done(d0 + 1, "postrst");
    checks++; if (res_s !== 2'b00) begin errors++; $display("FAIL postrst_result: got %b required 00", res_s); end
    checks++; if (cnt_s !== 5'd16) begin errors++; $display("FAIL postrst_cnt: got %0d required 16", cnt_s); end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_match();
    test_fault();
    test_timeout();
    test_framing();
    test_arm_guard();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
